// File: rtl/hazard_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_control_unit_pkg
// Shared definitions for the pipeline hazard control slice:
//   - hcu_state_e : control FSM state encoding (RUN=0, FLUSH=1, MEM_WAIT=2)
//   - HCU_REG_W   : width of register specifiers used in hazard compares
//   - opcode and nop constants used by the surrounding pipeline
// ---------------------------------------------------------------------------
package hazard_control_unit_pkg;

  localparam int HCU_REG_W = 5;

  typedef logic [HCU_REG_W-1:0] hcu_reg_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hcu_state_e;

  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

endpackage

// File: rtl/hazard_control_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_control_unit_if
// Groups the decode/execute/branch/memory status inputs and the stall/flush
// control outputs of the hazard control unit.
//   master : pipeline side, drives i_* and observes o_*
//   slave  : hazard control unit, observes i_* and drives o_*
// ---------------------------------------------------------------------------
interface hazard_control_unit_if;
  import hazard_control_unit_pkg::*;

  hcu_reg_t   i_dec_rs1;
  hcu_reg_t   i_dec_rs2;
  logic       i_dec_uses_rs2;
  logic       i_ex_valid;
  logic       i_ex_is_load;
  hcu_reg_t   i_ex_rd;
  logic       i_br_mispredict;
  logic       i_mem_busy;

  logic       o_fu_stall;
  logic       o_dec_stall;
  logic       o_dec_flush;
  logic       o_ex_bubble;
  logic [1:0] o_state;

  modport master (
    output i_dec_rs1, i_dec_rs2, i_dec_uses_rs2, i_ex_valid, i_ex_is_load,
           i_ex_rd, i_br_mispredict, i_mem_busy,
    input  o_fu_stall, o_dec_stall, o_dec_flush, o_ex_bubble, o_state
  );

  modport slave (
    input  i_dec_rs1, i_dec_rs2, i_dec_uses_rs2, i_ex_valid, i_ex_is_load,
           i_ex_rd, i_br_mispredict, i_mem_busy,
    output o_fu_stall, o_dec_stall, o_dec_flush, o_ex_bubble, o_state
  );

endinterface

// File: rtl/hazard_control_unit_hazard_detect.sv
// ---------------------------------------------------------------------------
// hcu_hazard_detect
// Purely combinational load-use compare between the load in execute and the
// source registers of the instruction in decode.
//   i_ex_valid, i_ex_is_load, i_ex_rd : execute-stage load information
//   i_dec_rs1, i_dec_rs2              : decode source registers
//   i_dec_uses_rs2                    : rs2 is a real register operand
//   o_hazard                          : load-use hazard present this cycle
// ---------------------------------------------------------------------------
module hcu_hazard_detect
  import hazard_control_unit_pkg::*;
(
  input  logic     i_ex_valid,
  input  logic     i_ex_is_load,
  input  hcu_reg_t i_ex_rd,
  input  hcu_reg_t i_dec_rs1,
  input  hcu_reg_t i_dec_rs2,
  input  logic     i_dec_uses_rs2,
  output logic     o_hazard
);

  logic w_rs1Match;
  logic w_rs2Match;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard;
  // rs2 only matters when decode really reads it as a register.
  always_comb begin
    w_rs1Match = (i_ex_rd == i_dec_rs1);
    w_rs2Match = i_dec_uses_rs2 & (i_ex_rd == i_dec_rs2);
    o_hazard   = i_ex_valid & i_ex_is_load & (i_ex_rd != '0) &
                 (w_rs1Match | w_rs2Match);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
// Pipeline stall/flush controller. Arbitrates, in priority order, reset,
// branch mispredict flush, data-memory busy stall and load-use bubble.
//   clk, rst : pipeline clock, synchronous active-high reset
//   bus      : hazard_control_unit_if.slave (status in, stall/flush out)
//   o_stall_cycles, o_flush_cycles : performance counters, present only when
//                                    the HCU_PERF_CNT_EN macro is defined
// Parameter FLUSH_CYCLES (1..15): cycles o_dec_flush is held per mispredict.
// ---------------------------------------------------------------------------
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_control_unit_if.slave bus
`ifdef HCU_PERF_CNT_EN
  ,
  output logic [31:0]          o_stall_cycles,
  output logic [31:0]          o_flush_cycles
`endif
);

  localparam logic [3:0] LP_RELOAD = 4'(FLUSH_CYCLES - 1);

  hcu_state_e r_state;
  hcu_state_e w_nextState;
  logic [3:0] r_flushCnt;
  logic [3:0] w_nextCnt;
  logic       w_hazard;
  logic       w_fuStall;
  logic       w_decStall;
  logic       w_decFlush;
  logic       w_exBubble;

  hcu_hazard_detect u_hazard_detect (
    .i_ex_valid     (bus.i_ex_valid),
    .i_ex_is_load   (bus.i_ex_is_load),
    .i_ex_rd        (bus.i_ex_rd),
    .i_dec_rs1      (bus.i_dec_rs1),
    .i_dec_rs2      (bus.i_dec_rs2),
    .i_dec_uses_rs2 (bus.i_dec_uses_rs2),
    .o_hazard       (w_hazard)
  );

  // State register and flush down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_flushCnt <= 4'd0;
    end else begin
      r_state    <= w_nextState;
      r_flushCnt <= w_nextCnt;
    end
  end

  // Next-state and Mealy outputs. A mispredict overrides every state; while
  // flushing, memory busy is deliberately ignored and picked up from RUN once
  // the flush ends. MEM_WAIT exits the same cycle busy drops, and a load-use
  // hazard still pending at that point is bubbled just as it would be in RUN.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_flushCnt;
    w_fuStall   = 1'b0;
    w_decStall  = 1'b0;
    w_decFlush  = 1'b0;
    w_exBubble  = 1'b0;

    if (rst) begin
      w_decFlush  = 1'b1;
      w_exBubble  = 1'b1;
      w_nextState = ST_RUN;
      w_nextCnt   = 4'd0;
    end else if (bus.i_br_mispredict) begin
      w_decFlush = 1'b1;
      w_exBubble = 1'b1;
      if (LP_RELOAD == 4'd0) begin
        w_nextState = ST_RUN;
        w_nextCnt   = 4'd0;
      end else begin
        w_nextState = ST_FLUSH;
        w_nextCnt   = LP_RELOAD;
      end
    end else begin
      case (r_state)
        ST_FLUSH: begin
          w_decFlush = 1'b1;
          w_exBubble = 1'b1;
          if (r_flushCnt <= 4'd1) begin
            w_nextState = ST_RUN;
            w_nextCnt   = 4'd0;
          end else begin
            w_nextCnt = r_flushCnt - 4'd1;
          end
        end
        default: begin
          if (bus.i_mem_busy) begin
            w_fuStall   = 1'b1;
            w_decStall  = 1'b1;
            w_nextState = ST_MEM_WAIT;
          end else if (w_hazard) begin
            w_fuStall   = 1'b1;
            w_decStall  = 1'b1;
            w_exBubble  = 1'b1;
            w_nextState = ST_RUN;
          end else begin
            w_nextState = ST_RUN;
          end
        end
      endcase
    end
  end

  // Drive the interface outputs.
  always_comb begin
    bus.o_fu_stall  = w_fuStall;
    bus.o_dec_stall = w_decStall;
    bus.o_dec_flush = w_decFlush;
    bus.o_ex_bubble = w_exBubble;
    bus.o_state     = r_state;
  end

`ifdef HCU_PERF_CNT_EN
  // Stall/flush cycle counters; they wrap naturally and ignore reset cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stall_cycles <= 32'd0;
      o_flush_cycles <= 32'd0;
    end else begin
      if (w_decStall) o_stall_cycles <= o_stall_cycles + 32'd1;
      if (w_decFlush) o_flush_cycles <= o_flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, meaning number of consecutive cycles o_dec_flush is asserted per mispredict (legal 1..15).
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_dec_rs1  input  5  rs1 of the instruction held in decode.
REQ-005 i_dec_rs2  input  5  rs2 of the instruction held in decode.
REQ-006 i_dec_uses_rs2  input  1  decode src2 type is register (R, S and B types).
REQ-007 i_ex_valid  input  1  execute stage holds a real instruction.
REQ-008 i_ex_is_load  input  1  execute instruction is a load.
REQ-009 i_ex_rd  input  5  execute destination register.
REQ-010 i_br_mispredict  input  1  single-cycle pulse from execute: branch or jump resolved against its prediction.
REQ-011 i_mem_busy  input  1  data memory cannot accept or complete the current access.
REQ-012 o_fu_stall  output  1  fetch holds its PC and instruction.
REQ-013 o_dec_stall  output  1  decode holds its buffer; drives the decode unit's exec-stall input.
REQ-014 o_dec_flush  output  1  decode loads nop/invalid PC; drives the decode unit's exec-flush input.
REQ-015 o_ex_bubble  output  1  execute latches a nop instead of the decode output.
REQ-016 o_state  output  2  current FSM state: RUN=0, FLUSH=1, MEM_WAIT=2.
REQ-017 o_stall_cycles, o_flush_cycles  output  32 each  performance counters (only with HCU_PERF_CNT_EN).

Function
REQ-018 Load-use hazard = i_ex_valid & i_ex_is_load & (i_ex_rd != 0) & ((i_ex_rd == i_dec_rs1) | (i_dec_uses_rs2 & (i_ex_rd == i_dec_rs2))); computed combinationally.
REQ-019 FSM states RUN, FLUSH, MEM_WAIT; priority each cycle: rst > i_br_mispredict > i_mem_busy > load-use > none.
REQ-020 Mispredict in any state: same cycle o_dec_flush=1, o_ex_bubble=1, o_fu_stall=0, o_dec_stall=0; next state FLUSH with down-counter = FLUSH_CYCLES-1, or RUN when FLUSH_CYCLES=1.
REQ-021 FLUSH: o_dec_flush=1, o_ex_bubble=1, stalls 0; counter decrements; counter==1 -> next state RUN; a new mispredict reloads the counter to FLUSH_CYCLES-1.
REQ-022 i_mem_busy high with no mispredict: o_fu_stall=1, o_dec_stall=1, o_ex_bubble=0 (execute holds its instruction); next state MEM_WAIT; in MEM_WAIT, i_mem_busy low -> RUN the same cycle outputs deassert (Mealy), next state RUN.
REQ-023 i_mem_busy high during FLUSH: ignored until the flush count ends; then takes effect on the next cycle.
REQ-024 Load-use in RUN: o_fu_stall=1, o_dec_stall=1, o_ex_bubble=1 for exactly the hazard cycle; no state change; the bubble clears the hazard next cycle.
REQ-025 No hazard: all control outputs 0; state RUN.
REQ-026 rd = x0 never produces a hazard; rs2 compare ignored when i_dec_uses_rs2=0.

Reset
REQ-027 rst high: state RUN, flush counter 0, perf counters 0; while rst is high, o_fu_stall=0, o_dec_stall=0, o_dec_flush=1, o_ex_bubble=1 and o_state=0.
REQ-028 rst asserted mid-FLUSH or mid-MEM_WAIT aborts the sequence; the first cycle after rst is RUN.

Configuration
REQ-029 Macro HCU_PERF_CNT_EN defined: o_stall_cycles counts cycles with o_dec_stall=1 and o_flush_cycles counts cycles with o_dec_flush=1 outside reset; both are 32-bit and wrap from 0xFFFFFFFF to 0.
REQ-030 Macro absent: the counter ports and logic do not exist; all other behaviour is identical.

Structure
REQ-031 The state encoding (RUN/FLUSH/MEM_WAIT) and the hazard-comparison width belong in the shared macros header beside the opcode and nop definitions.
REQ-032 There is one sub-module, hcu_hazard_detect: purely combinational load-use compare (REQ-018, REQ-026).

Verification
REQ-033 ex load rd=5, dec rs1=5 -> one cycle of o_fu_stall=o_dec_stall=o_ex_bubble=1, then all 0; o_state stays 0.
REQ-034 ex load rd=0, dec rs1=0 -> no stall; ex load rd=7, dec rs2=7 with i_dec_uses_rs2=0 -> no stall.
REQ-035 Mispredict pulse, FLUSH_CYCLES=2 -> o_dec_flush=1 for 2 cycles, o_state 1 then 0; a second pulse in cycle 2 -> flush extends to 3 cycles total.
REQ-036 i_mem_busy high 4 cycles -> stalls high for exactly those 4 cycles with o_ex_bubble=0, o_state=2 for cycles 2-4; o_stall_cycles increments by 4.
REQ-037 Mispredict coincident with i_mem_busy and a load-use hazard -> flush wins: o_fu_stall=0, o_dec_flush=1; MEM_WAIT entered only after the flush completes.
REQ-038 rst asserted during MEM_WAIT -> next cycle o_state=0 and perf counters 0.
